// File: rtl/err_frame_pkg.sv
// ============================================================================
// Module      : err_frame_pkg
// Description : Shared types and constants for the error-count frame serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package err_frame_pkg;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;
    localparam int         HDR_W       = 8;
    localparam int         CSUM_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int frame_len(input int num_ch, input int cnt_w);
        return HDR_W + num_ch * cnt_w + CSUM_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module      : sync_edge_det
// Description : Multi-flop synchroniser followed by a one-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    generate
        if (SYNC_STAGES > 1) begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            end
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= async_in;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= r_sync[SYNC_STAGES-1];
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/err_frame_serializer.sv
// ============================================================================
// Module      : err_frame_serializer
// Description : Snapshots the per-chain error counts and shifts out a framed,
//               checksummed record one bit per Pi data clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module err_frame_serializer
    import err_frame_pkg::*;
#(
    parameter int         NUM_CH      = 20,
    parameter int         CNT_W       = 12,
    parameter logic [7:0] HDR         = HDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    save_data,
    input  logic                    data_clk,
    input  logic [NUM_CH*CNT_W-1:0] ERR_CNT_BUS,
    output logic                    DATA_OUT,
    output logic                    BUSY,
    output logic                    FRAME_DONE,
    output logic [7:0]              FRAME_CNT
);

    localparam int                 FRAME_LEN = frame_len(NUM_CH, CNT_W);
    localparam int                 IDX_W     = $clog2(FRAME_LEN + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    logic                  w_save_pulse;
    logic                  w_dclk_pulse;
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_count;
    logic [FRAME_LEN-1:0]  r_shadow;
    logic [FRAME_LEN-1:0]  w_frame;
    logic [CSUM_W-1:0]     w_csum;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_frame_cnt;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_save (
        .clk      (CLK),
        .rst      (RST),
        .async_in (save_data),
        .rise     (w_save_pulse)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dclk (
        .clk      (CLK),
        .rst      (RST),
        .async_in (data_clk),
        .rise     (w_dclk_pulse)
    );

    // Frame image: header, channel 0 first, checksum in the low bits.
    always_comb begin
        w_csum  = '0;
        w_frame = '0;
        w_frame[FRAME_LEN-1 -: HDR_W] = HDR;
        for (int k = 0; k < NUM_CH; k++) begin
            w_csum = w_csum + CSUM_W'(ERR_CNT_BUS[k*CNT_W +: CNT_W]);
            w_frame[FRAME_LEN-1-HDR_W-k*CNT_W -: CNT_W] = ERR_CNT_BUS[k*CNT_W +: CNT_W];
        end
        w_frame[CSUM_W-1:0] = w_csum;
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_count     = 1'b0;
        DATA_OUT    = 1'b0;
        BUSY        = 1'b0;
        FRAME_DONE  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_save_pulse) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                BUSY        = 1'b1;
                w_load      = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                BUSY     = 1'b1;
                DATA_OUT = r_shadow[FRAME_LEN-1];
                // A save request aborts the frame and discards any coincident bit clock.
                if (w_save_pulse) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_dclk_pulse) begin
                    w_shift = 1'b1;
                    if (r_idx == LAST_IDX) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                FRAME_DONE  = 1'b1;
                w_count     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shadow    <= '0;
            r_idx       <= '0;
            r_frame_cnt <= 8'd0;
        end else begin
            if (w_load) begin
                r_shadow <= w_frame;
                r_idx    <= '0;
            end else if (w_shift) begin
                r_shadow <= {r_shadow[FRAME_LEN-2:0], 1'b0};
                r_idx    <= r_idx + 1'b1;
            end
            if (w_count) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign FRAME_CNT = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_err_frame_serializer.sv
// ============================================================================
// Module      : tb_err_frame_serializer
// Description : Directed self-checking bench for err_frame_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_err_frame_serializer;

    localparam int NCH = 20;
    localparam int CW  = 12;
    localparam int FL  = 264;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            save_data = 1'b0;
    logic            data_clk  = 1'b0;
    logic [NCH*CW-1:0] bus = '0;
    logic            DATA_OUT, BUSY, FRAME_DONE;
    logic [7:0]      FRAME_CNT;

    // Small instance used for the counter-wrap run (28-bit frames).
    logic            s_save = 1'b0;
    logic            s_dclk = 1'b0;
    logic [3:0]      s_bus  = 4'h9;
    logic            s_dout, s_busy, s_done;
    logic [7:0]      s_cnt;

    int pass_cnt   = 0;
    int total      = 0;
    int done_cnt   = 0;
    int s_done_cnt = 0;
    int d0;
    logic [FL-1:0] got;
    logic [FL-1:0] exp_f;
    logic [27:0]   s_got;

    err_frame_serializer dut (
        .CLK(CLK), .RST(RST), .save_data(save_data), .data_clk(data_clk),
        .ERR_CNT_BUS(bus), .DATA_OUT(DATA_OUT), .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT)
    );

    err_frame_serializer #(.NUM_CH(1), .CNT_W(4)) dut_small (
        .CLK(CLK), .RST(RST), .save_data(s_save), .data_clk(s_dclk),
        .ERR_CNT_BUS(s_bus), .DATA_OUT(s_dout), .BUSY(s_busy),
        .FRAME_DONE(s_done), .FRAME_CNT(s_cnt)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FRAME_DONE) done_cnt++;
        if (s_done)     s_done_cnt++;
    end

    task automatic check(input string tag, input logic [FL-1:0] obs, input logic [FL-1:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [FL-1:0] model(input logic [NCH*CW-1:0] b);
        logic [FL-1:0] f;
        logic [15:0]   s;
        f = '0;
        s = '0;
        f[FL-1 -: 8] = 8'hA5;
        for (int k = 0; k < NCH; k++) begin
            f[FL-9-k*CW -: CW] = b[k*CW +: CW];
            s = s + {4'h0, b[k*CW +: CW]};
        end
        f[15:0] = s;
        return f;
    endfunction

    // All drivers change on falling edges and every task ends on a falling edge.
    task automatic pi_save();
        save_data = 1'b1;
        repeat (6) @(negedge CLK);
        save_data = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic pi_bit();
        data_clk = 1'b1;
        repeat (4) @(negedge CLK);
        data_clk = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic shift_bits(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            if (start + i < FL) got[FL-1-(start+i)] = DATA_OUT;
            pi_bit();
        end
    endtask

    task automatic small_frame();
        s_save = 1'b1;
        repeat (3) @(negedge CLK);
        s_save = 1'b0;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 28; i++) begin
            s_got[27-i] = s_dout;
            s_dclk = 1'b1;
            repeat (2) @(negedge CLK);
            s_dclk = 1'b0;
            repeat (2) @(negedge CLK);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_data_out",   DATA_OUT,   0);
        check("reset_busy",       BUSY,       0);
        check("reset_frame_done", FRAME_DONE, 0);
        check("reset_frame_cnt",  FRAME_CNT,  0);

        // All channels 1
        for (int k = 0; k < NCH; k++) bus[k*CW +: CW] = 12'h001;
        d0 = done_cnt;
        pi_save();
        check("load_busy", BUSY, 1);
        check("load_msb",  DATA_OUT, 1);
        shift_bits(FL, 0);
        check("ones_header", got[FL-1 -: 8], 8'hA5);
        check("ones_csum",   got[15:0], 16'h0014);
        check("ones_frame",  got, model(bus));
        check("ones_done_pulses", done_cnt - d0, 1);
        check("ones_frame_cnt", FRAME_CNT, 1);
        check("ones_busy_after", BUSY, 0);

        // Channel k = k
        for (int k = 0; k < NCH; k++) bus[k*CW +: CW] = 12'(k);
        pi_save();
        shift_bits(FL, 0);
        check("ramp_csum",  got[15:0], 16'h00BE);
        check("ramp_ch19",  got[16 +: 12], 12'd19);
        check("ramp_frame", got, model(bus));

        // All channels saturated: checksum wraps
        for (int k = 0; k < NCH; k++) bus[k*CW +: CW] = 12'hFFF;
        pi_save();
        shift_bits(FL, 0);
        check("sat_csum",  got[15:0], 16'h3FEC);
        check("sat_frame", got, model(bus));
        check("sat_frame_cnt", FRAME_CNT, 3);

        // Snapshot isolation: bus changes mid-shift
        for (int k = 0; k < NCH; k++) bus[k*CW +: CW] = 12'(k);
        exp_f = model(bus);
        pi_save();
        shift_bits(50, 0);
        for (int k = 0; k < NCH; k++) bus[k*CW +: CW] = 12'hABC;
        shift_bits(FL - 50, 50);
        check("snap_frame", got, exp_f);
        check("snap_csum",  got[15:0], 16'h00BE);

        // Abort after 100 bits, then complete
        for (int k = 0; k < NCH; k++) bus[k*CW +: CW] = 12'(3*k + 7);
        d0 = done_cnt;
        pi_save();
        shift_bits(100, 0);
        pi_save();
        check("abort_msb", DATA_OUT, 1);
        check("abort_busy", BUSY, 1);
        check("abort_frame_cnt", FRAME_CNT, 4);
        check("abort_no_done", done_cnt - d0, 0);
        shift_bits(FL, 0);
        check("abort_frame", got, model(bus));
        check("abort_frame_cnt_after", FRAME_CNT, 5);

        // Coincident save and bit clock in SHIFT
        pi_save();
        shift_bits(10, 0);
        save_data = 1'b1;
        data_clk  = 1'b1;
        repeat (6) @(negedge CLK);
        save_data = 1'b0;
        data_clk  = 1'b0;
        repeat (4) @(negedge CLK);
        check("coinc_msb", DATA_OUT, 1);
        shift_bits(FL, 0);
        check("coinc_frame", got, model(bus));
        check("coinc_frame_cnt", FRAME_CNT, 6);

        // Bit clocks while idle
        repeat (3) pi_bit();
        check("idle_data_out", DATA_OUT, 0);
        check("idle_busy", BUSY, 0);
        check("idle_frame_cnt", FRAME_CNT, 6);

        // Reset mid-frame
        pi_save();
        shift_bits(50, 0);
        d0 = done_cnt;
        RST = 1'b1;
        @(negedge CLK);
        check("rst_data_out", DATA_OUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_frame_cnt", FRAME_CNT, 0);
        RST = 1'b0;
        repeat (3) pi_bit();
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle_data_out", DATA_OUT, 0);
        check("rst_idle_busy", BUSY, 0);

        // Counter wrap on the small instance
        s_done_cnt = 0;
        small_frame();
        check("small_frame", s_got, 28'hA590009);
        check("small_cnt1", s_cnt, 1);
        for (int f = 1; f < 256; f++) small_frame();
        repeat (2) @(negedge CLK);
        check("wrap_cnt", s_cnt, 0);
        check("wrap_done_pulses", s_done_cnt, 256);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

`default_nettype wire
